izh_synapse: RTL and testbench
==============================

Name: izh_synapse

Overview:
- Receive end of the neuron spike interface: consumes the 1-bit spike train an izh neuron emits and turns it into the 8-bit input current that drives the next neuron.
- Each spike rising edge adds a weight to a synaptic current register. The current decays exponentially on a divided tick and saturates at full scale.
- Used to chain neurons on-die, or to loop a neuron's spike output back to a current input.

Parameters:
- WIDTH, 8, bit width of current and weight (unsigned)
- DECAY_SHIFT, 3, decay per tick is I >> DECAY_SHIFT (tau ≈ 2^DECAY_SHIFT ticks)
- TICK_DIV, 4, clock cycles per decay tick; must be ≥1

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- spike_in  in  1  spike train from the presynaptic neuron; level, may stay high for several cycles
- weight  in  WIDTH  synaptic weight, sampled in the cycle a spike edge is detected
- current  out  WIDTH  postsynaptic current, registered
- spike_seen  out  1  one-cycle pulse, registered, coincident with the current update caused by an edge
- active  out  1  high while in state ACTIVE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: current=0, spike_seen=0, active=0, state=IDLE, tick_cnt=0, spike_d=0.
- Edge detect: spike_d registers spike_in. edge = spike_in & ~spike_d. A held-high spike counts once. A spike_in already high when reset deasserts counts as an edge on the first cycle.
- Tick: tick_cnt counts 0..TICK_DIV-1 only in ACTIVE. tick = (state==ACTIVE) & (tick_cnt==TICK_DIV-1), after which tick_cnt wraps to 0. tick_cnt is forced to 0 in IDLE. Edges in ACTIVE do not restart tick_cnt.
- Decay function D(I):
  - d = I >> DECAY_SHIFT.
  - If d==0 and I>0, then d=1, so the current always reaches 0.
  - D(I) = I - d.
- Update, one cycle latency (edge in cycle n gives the new current visible in cycle n+1):
  - tick only: current <= D(current)
  - edge only: current <= sat(current + weight)
  - tick and edge in the same cycle: current <= sat(D(current) + weight), decay applied first
  - neither: hold
  - sat clamps the WIDTH+1-bit sum to 2^WIDTH-1.
- spike_seen <= edge, every cycle.
- State machine:
  - IDLE → ACTIVE when edge and the next current is nonzero. weight=0 keeps IDLE, but spike_seen still pulses.
  - ACTIVE → IDLE when the next current==0. tick_cnt is cleared on the transition.
  - active = (state==ACTIVE). It equals (current!=0) in every cycle.
- Reset mid-operation: all registers return to reset values on the next edge, regardless of state. A pending spike is dropped.
- Width rules: all arithmetic is unsigned. The sum is computed at WIDTH+1 bits before saturation. There is no wrap-around on current.

Decomposition:
- Package izh_pkg:
  - localparam CUR_W = 8, CUR_MAX = 8'hFF
  - state enum typedef syn_state_t {IDLE, ACTIVE}
  - function sat_add(a, b) shared with the neuron's input stage
- One sub-module, izh_syn_decay: combinational D(I) parameterised by WIDTH and DECAY_SHIFT, reused by future leak blocks.

Test Plan (defaults WIDTH=8, DECAY_SHIFT=3, TICK_DIV=4):
- Reset: assert reset 2 cycles with spike_in=1 → current=0, active=0, spike_seen=0. On deassert with spike_in still high, one edge: current=weight next cycle.
- Single spike: weight=80, spike_in high 1 cycle → next cycle current=80, spike_seen=1, active=1. After 4 cycles 70, after 8 cycles 62, after 12 cycles 55.
- Held spike: weight=20, spike_in high 10 cycles → exactly one spike_seen pulse. current=20, then decays 20→18→16.
- Saturation and coincidence: current=200, edge with weight=100 on a tick cycle → D(200)=175, sum 275 clamps to 255.
- Tail to zero: single spike with weight=5 → current 5,4,3,2,1,0, one step every 4 cycles. active falls in the same cycle current reaches 0. tick_cnt=0 in IDLE.
- Reset mid-decay: current=120 in ACTIVE, reset pulsed 1 cycle → next cycle current=0, state=IDLE. A following spike with weight=10 gives current=10.

Source files
------------

// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - shared types, limits and saturating add for the izh neuron family
package izh_pkg;

  localparam int CUR_W = 8;
  localparam logic [CUR_W-1:0] CUR_MAX = 8'hFF;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } syn_state_t;

  // Unsigned add clamped to full scale; used by neuron input stages too.
  function automatic logic [CUR_W-1:0] sat_add(input logic [CUR_W-1:0] a,
                                               input logic [CUR_W-1:0] b);
    logic [CUR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CUR_W] ? CUR_MAX : s[CUR_W-1:0];
  endfunction

endpackage

// File: rtl/izh_syn_decay.sv
// rtl/izh_syn_decay.sv - combinational exponential decay step D(I) = I - max(I >> shift, I != 0)
module izh_syn_decay #(
  parameter int WIDTH       = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] decayed
);

  logic [WIDTH-1:0] d;

  always_comb begin
    d = cur >> DECAY_SHIFT;
    // Small currents still lose one LSB per step so the tail always reaches zero.
    if (d == '0 && cur != '0) d = WIDTH'(1);
    decayed = cur - d;
  end

endmodule

// File: rtl/izh_synapse.sv
// rtl/izh_synapse.sv - spike-edge driven synaptic current with ticked exponential decay
module izh_synapse
  import izh_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DECAY_SHIFT = 3,
  parameter int TICK_DIV    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic [WIDTH-1:0] weight,
  output logic [WIDTH-1:0] current,
  output logic             spike_seen,
  output logic             active
);

  localparam int TC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_DIV - 1);

  syn_state_t       state, state_next;
  logic             spike_d;
  logic             spike_edge;
  logic             tick;
  logic [TC_W-1:0]  tick_cnt, tick_cnt_next;
  logic [WIDTH-1:0] decayed, base, cur_next;
  logic [WIDTH:0]   sum;

  izh_syn_decay #(
    .WIDTH      (WIDTH),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_decay (
    .cur    (current),
    .decayed(decayed)
  );

  always_comb begin
    spike_edge = spike_in & ~spike_d;
    tick       = (state == ACTIVE) && (tick_cnt == TC_LAST);
    // Decay first, then add the weight when both land in the same cycle.
    base       = tick ? decayed : current;
    sum        = {1'b0, base} + {1'b0, weight};
    cur_next   = base;
    if (spike_edge) cur_next = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (spike_edge && cur_next != '0) state_next = ACTIVE;
      ACTIVE:  if (cur_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_next = '0;
    if (state == ACTIVE && state_next == ACTIVE)
      tick_cnt_next = tick ? '0 : tick_cnt + TC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      spike_d    <= 1'b0;
      current    <= '0;
      spike_seen <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      spike_d    <= spike_in;
      current    <= cur_next;
      spike_seen <= spike_edge;
    end
  end

  assign active = (state == ACTIVE);

endmodule

// File: tb/tb_izh_synapse.sv
// tb/tb_izh_synapse.sv - directed and randomized checks of izh_synapse against a behavioural model
module tb_izh_synapse;

  localparam int TDIV = 4;
  localparam int DSH  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spike_in = 1'b0;
  logic [7:0] weight = 8'd0;
  logic [7:0] current;
  logic       spike_seen;
  logic       active;

  int vectors = 0;
  int miscompares = 0;

  int m_cur = 0;
  int m_age = 0;
  bit m_prev = 1'b0;
  bit m_seen = 1'b0;

  izh_synapse #(
    .WIDTH      (8),
    .DECAY_SHIFT(DSH),
    .TICK_DIV   (TDIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .weight    (weight),
    .current   (current),
    .spike_seen(spike_seen),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: current rises by weight on each new spike, loses max(I/8,1) every
  // TDIV cycles spent nonzero, clamps at 255; active simply means current is nonzero.
  task automatic model(input logic s, input logic [7:0] w, input logic r);
    int  base, nxt, d;
    bit  e, t;
    if (r) begin
      m_cur = 0; m_age = 0; m_prev = 1'b0; m_seen = 1'b0;
    end else begin
      e = s && !m_prev;
      t = (m_cur != 0) && ((m_age % TDIV) == TDIV - 1);
      base = m_cur;
      if (t) begin
        d = m_cur >> DSH;
        if (d == 0) d = 1;
        base = m_cur - d;
      end
      nxt = e ? base + int'(w) : base;
      if (nxt > 255) nxt = 255;
      m_age  = (nxt == 0 || m_cur == 0) ? 0 : m_age + 1;
      m_prev = s;
      m_cur  = nxt;
      m_seen = e;
    end
  endtask

  task automatic step(input logic s, input logic [7:0] w, input logic r);
    @(negedge clk);
    spike_in = s;
    weight   = w;
    reset    = r;
    model(s, w, r);
    @(posedge clk);
    #1;
    chk("current", 32'(current), 32'(m_cur));
    chk("spike_seen", 32'(spike_seen), 32'(m_seen));
    chk("active", 32'(active), 32'(m_cur != 0));
  endtask

  initial begin
    int pulses;
    logic r, s;
    logic [7:0] w;

    // Reset held with spike high, then release: first cycle counts as an edge
    step(1'b1, 8'd33, 1'b1);
    step(1'b1, 8'd33, 1'b1);
    chk("rst_current", 32'(current), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    step(1'b1, 8'd33, 1'b0);
    chk("rst_release_edge", 32'(current), 32'd33);

    // Single spike of 80 then decay 70, 62, 55
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd80, 1'b0);
    chk("single_cur", 32'(current), 32'd80);
    chk("single_seen", 32'(spike_seen), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0);
    chk("decay_4", 32'(current), 32'd70);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0);
    chk("decay_8", 32'(current), 32'd62);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0);
    chk("decay_12", 32'(current), 32'd55);

    // Held spike produces a single pulse
    step(1'b0, 8'd0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'd20, 1'b0);
      if (spike_seen === 1'b1) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_cur", 32'(current), 32'd16);

    // Saturation with edge on a tick cycle: D(200)=175, +100 clamps to 255
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd200, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd100, 1'b0);
    chk("sat_cur", 32'(current), 32'd255);

    // Tail to zero from weight 5
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd5, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b0, 8'd0, 1'b0);
    chk("tail_one", 32'(current), 32'd1);
    chk("tail_one_active", 32'(active), 32'd1);
    step(1'b0, 8'd0, 1'b0);
    chk("tail_zero", 32'(current), 32'd0);
    chk("tail_idle", 32'(active), 32'd0);

    // Zero weight edge: pulse but stay idle
    step(1'b1, 8'd0, 1'b0);
    chk("w0_seen", 32'(spike_seen), 32'd1);
    chk("w0_idle", 32'(active), 32'd0);

    // Reset mid-decay
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd120, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd50, 1'b1);
    chk("mid_rst_cur", 32'(current), 32'd0);
    chk("mid_rst_idle", 32'(active), 32'd0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd10, 1'b0);
    chk("post_rst_spike", 32'(current), 32'd10);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) == 0);
      s = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      step(s, w, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
